bus_master_if: RTL and testbench

BUS_MASTER_IF -- requirements
Module: bus_master_if

---
 rtl/bus_master_if.sv | 123 ++++++++++++
 tb/tb_bus_master_if.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bus_master_if.sv
// Single-outstanding bus master: takes a user command, requests the arbiter,
// waits for grant and ack (with timeout), then holds the response until taken.
module bus_master_if #(
  parameter int TIMEOUT = 16,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_slave,
  input  logic [DW-1:0] cmd_data,
  output logic          req,
  output logic          slave_id,
  output logic [DW-1:0] m_data_out,
  input  logic          gnt,
  input  logic          ack,
  input  logic [DW-1:0] m_data_in,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [15:0]   txn_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RSP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          slave_q, slave_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   txn_cnt_q, txn_cnt_d;
  logic          tmo_hit;
  logic          busy;

  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      slave_q    <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      txn_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      slave_q    <= slave_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      txn_cnt_q  <= txn_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    slave_d    = slave_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    txn_cnt_d  = txn_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          slave_d = cmd_slave;
          data_d  = cmd_data;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // ack is never a completion here, even alongside gnt
        tmo_d = tmo_q + 8'd1;
        if (tmo_hit) begin
          state_d    = RSP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (gnt) begin
          state_d = XFER;
        end
      end
      XFER: begin
        // ack beats a coincident timeout
        tmo_d = tmo_q + 8'd1;
        if (ack) begin
          state_d    = RSP;
          rsp_err_d  = 1'b0;
          rsp_data_d = m_data_in;
          txn_cnt_d  = txn_cnt_q + 16'd1;
        end else if (tmo_hit) begin
          state_d    = RSP;
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else if (!gnt) begin
          state_d = REQ;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == REQ) || (state_q == XFER);
  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RSP);
  assign req        = busy;
  assign slave_id   = busy & slave_q;
  assign m_data_out = busy ? data_q : '0;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign txn_cnt    = txn_cnt_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Randomized bench for bus_master_if; expected outcome of each transaction is
// derived from the per-cycle gnt/ack schedule, not from the FSM structure.
module tb_bus_master_if;
  localparam int TIMEOUT = 16;
  localparam int DW      = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_slave;
  logic [DW-1:0] cmd_data;
  logic          req, slave_id;
  logic [DW-1:0] m_data_out;
  logic          gnt, ack;
  logic [DW-1:0] m_data_in;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [15:0]   txn_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_cnt;

  bus_master_if #(.TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_slave(cmd_slave), .cmd_data(cmd_data),
    .req(req), .slave_id(slave_id), .m_data_out(m_data_out),
    .gnt(gnt), .ack(ack), .m_data_in(m_data_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .txn_cnt(txn_cnt)
  );

  always #5 clk = ~clk;

  task automatic test_reset(input string name);
    logic [84:0] got, exp;
    rst = 1'b1; cmd_valid = 1'b0; cmd_slave = 1'b0; cmd_data = '0;
    gnt = 1'b0; ack = 1'b0; m_data_in = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    got = {cmd_ready, req, slave_id, m_data_out, rsp_valid, rsp_data, rsp_err, txn_cnt};
    exp = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s outputs got=%h exp=%h", name, got, exp);
    end
    model_cnt = '0;
  endtask

  // Transfer phase holds in cycle k exactly when gnt was sampled at k-1, so the
  // first k>=1 with gnt[k-1] & ack[k] completes; none by TIMEOUT-1 means abort.
  task automatic run_txn(input string name, input logic sl, input logic [DW-1:0] d,
                         input logic [15:0] g, input logic [15:0] a, input int bp);
    logic [DW-1:0] rd [TIMEOUT];
    int            ks, n_end;
    logic          exp_err;
    logic [DW-1:0] exp_data;
    ks = -1;
    for (int k = 0; k < TIMEOUT; k++) rd[k] = $urandom;
    for (int k = 1; k < TIMEOUT; k++) if (ks < 0 && g[k-1] && a[k]) ks = k;
    exp_err  = (ks < 0);
    n_end    = exp_err ? TIMEOUT : ks + 1;
    exp_data = exp_err ? '0 : rd[ks];
    if (!exp_err) model_cnt = model_cnt + 16'd1;

    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_slave = sl; cmd_data = d;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept cmd_ready=%b exp=1", name, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0; cmd_slave = ~sl; cmd_data = $urandom;

    for (int k = 0; k < n_end; k++) begin
      gnt = g[k]; ack = a[k]; m_data_in = rd[k]; rsp_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({req, slave_id, m_data_out, rsp_valid, cmd_ready} !== {1'b1, sl, d, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s busy_cyc%0d req=%b sid=%b mdo=%h rv=%b cr=%b exp req=1 sid=%b mdo=%h rv=0 cr=0",
                 name, k, req, slave_id, m_data_out, rsp_valid, cmd_ready, sl, d);
      end
      @(posedge clk);
      #1;
    end

    gnt = 1'b0; ack = 1'($urandom); m_data_in = $urandom; rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, txn_cnt, req, slave_id, m_data_out, cmd_ready}
        !== {1'b1, exp_err, exp_data, model_cnt, 1'b0, 1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL %s rsp rv=%b err=%b data=%h cnt=%h req=%b sid=%b mdo=%h cr=%b exp rv=1 err=%b data=%h cnt=%h req=0 sid=0 mdo=0 cr=0",
               name, rsp_valid, rsp_err, rsp_data, txn_cnt, req, slave_id, m_data_out, cmd_ready,
               exp_err, exp_data, model_cnt);
    end

    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1 gnt = 1'($urandom); ack = 1'($urandom); m_data_in = $urandom;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_data, cmd_ready, req} !== {1'b1, exp_err, exp_data, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s hold%0d rv=%b err=%b data=%h cr=%b req=%b exp rv=1 err=%b data=%h cr=0 req=0",
                 name, i, rsp_valid, rsp_err, rsp_data, cmd_ready, req, exp_err, exp_data);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; gnt = 1'b0; ack = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, req, txn_cnt} !== {1'b1, 1'b0, 1'b0, model_cnt}) begin
      failures++;
      $display("FAIL %s release cr=%b rv=%b req=%b cnt=%h exp cr=1 rv=0 req=0 cnt=%h",
               name, cmd_ready, rsp_valid, req, txn_cnt, model_cnt);
    end
  endtask

  task automatic test_reset_mid_xfer(input string name);
    logic [84:0] got, exp;
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_slave = 1'b1; cmd_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 cmd_valid = 1'b0; gnt = 1'b1; ack = 1'b0;
    @(posedge clk);
    #1 gnt = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b1) begin
      failures++;
      $display("FAIL %s pre_reset req=%b exp=1", name, req);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; gnt = 1'b0;
    @(negedge clk);
    got = {cmd_ready, req, slave_id, m_data_out, rsp_valid, rsp_data, rsp_err, txn_cnt};
    exp = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 16'h0};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s outputs got=%h exp=%h", name, got, exp);
    end
    model_cnt = '0;
  endtask

  task automatic test_wrap(input string name);
    @(negedge clk);
    force dut.txn_cnt_q = 16'hFFFF;
    #1 release dut.txn_cnt_q;
    model_cnt = 16'hFFFF;
    checks++;
    if (txn_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL %s preload cnt=%h exp=ffff", name, txn_cnt);
    end
    run_txn(name, 1'b0, 32'h0BAD_F00D, 16'h0001, 16'h0002, 0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++)
      run_txn("random", 1'($urandom), $urandom, 16'($urandom), 16'($urandom & $urandom),
              $urandom_range(0, 3));
  endtask

  initial begin
    test_reset("reset");
    // gnt in first REQ cycle, ack in first XFER cycle: rsp_valid on the third
    // edge after the acceptance edge's cycle
    run_txn("basic", 1'b1, 32'hA5A5_0001, 16'h0001, 16'h0002, 0);
    run_txn("delayed_gnt", 1'b0, 32'h1357_9BDF, 16'hFFE0, 16'h0080, 1);
    run_txn("timeout", 1'b1, 32'hCAFE_0002, 16'h0000, 16'hFFFF, 0);
    run_txn("gnt_at_last", 1'b0, 32'h0000_0003, 16'h8000, 16'hFFFF, 0);
    run_txn("gnt_loss", 1'b1, 32'h7777_0004, 16'h0005, 16'h0008, 0);
    run_txn("ack_with_gnt_ignored", 1'b0, 32'h0000_0005, 16'h0002, 16'h0006, 0);
    run_txn("ack_race_tmo", 1'b1, 32'h0000_0006, 16'h4000, 16'h8000, 0);
    run_txn("backpressure", 1'b1, 32'h2468_ACE0, 16'h0001, 16'h0002, 3);
    test_reset_mid_xfer("reset_mid_xfer");
    test_wrap("wrap");
    test_random(25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
